// File: rtl/ariane_host_finish_ctrl.sv
// End-of-test controller: latches per-hart ECALL snapshots, then reports each hart's
// cycle/instret and milli-IPC (instret*1000/cycle) one at a time over valid/ready.
module ariane_host_finish_ctrl #(
    parameter int NUM_HARTS = 2,
    parameter int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_HARTS-1:0]      ex_i,
    input  logic [64*NUM_HARTS-1:0]   cause_i,
    input  logic [64*NUM_HARTS-1:0]   cycle_i,
    input  logic [64*NUM_HARTS-1:0]   instret_i,
    output logic                      rpt_valid_o,
    input  logic                      rpt_ready_i,
    output logic [HART_W-1:0]         rpt_hart_o,
    output logic [63:0]               rpt_cycle_o,
    output logic [63:0]               rpt_instret_o,
    output logic [63:0]               rpt_mipc_o,
    output logic                      busy_o,
    output logic                      all_done_o
);

    typedef enum logic [1:0] {IDLE, DIV, REPORT} state_e;

    state_e                state;
    logic [NUM_HARTS-1:0]  pend;
    logic [NUM_HARTS-1:0]  fin;
    logic [NUM_HARTS-1:0]  fin_nxt;
    logic [NUM_HARTS-1:0]  detect;
    logic [63:0]           snap_cycle   [NUM_HARTS];
    logic [63:0]           snap_instret [NUM_HARTS];
    logic [HART_W-1:0]     sel;
    logic [HART_W-1:0]     pick;
    logic                  any_pend;
    logic                  handshake;

    // Restoring divider datapath: quo starts as the dividend and fills with quotient bits.
    logic [63:0]           divisor;
    logic [63:0]           rem;
    logic [63:0]           quo;
    logic [6:0]            cnt;
    logic [64:0]           shifted;
    logic [63:0]           diff;
    logic                  fits;
    logic [63:0]           quo_nxt;

    assign handshake = rpt_valid_o & rpt_ready_i;

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            detect[h] = ex_i[h] && (cause_i[64*h +: 64] inside {64'h8, 64'h9, 64'hb});
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pick     = '0;
        any_pend = |pend;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (pend[h]) pick = HART_W'(h);
        end
    end

    always_comb begin
        shifted = {rem, quo[63]};
        fits    = shifted >= {1'b0, divisor};
        diff    = shifted[63:0] - divisor;
        quo_nxt = {quo[62:0], fits};
        fin_nxt = fin;
        if (handshake) fin_nxt[sel] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pend          <= '0;
            fin           <= '0;
            sel           <= '0;
            divisor       <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            rpt_valid_o   <= 1'b0;
            rpt_hart_o    <= '0;
            rpt_cycle_o   <= '0;
            rpt_instret_o <= '0;
            rpt_mipc_o    <= '0;
            busy_o        <= 1'b0;
            all_done_o    <= 1'b0;
            // NOTE: the snapshot arrays are reset explicitly; a stale snapshot must never survive a reset.
            for (int h = 0; h < NUM_HARTS; h++) begin
                snap_cycle[h]   <= '0;
                snap_instret[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (detect[h] && !pend[h] && !fin[h]) begin
                    pend[h]         <= 1'b1;
                    snap_cycle[h]   <= cycle_i[64*h +: 64];
                    snap_instret[h] <= instret_i[64*h +: 64];
                end
            end
            if (handshake) pend[sel] <= 1'b0;
            fin        <= fin_nxt;
            all_done_o <= &fin_nxt;

            case (state)
                IDLE: begin
                    if (any_pend) begin
                        sel           <= pick;
                        rpt_hart_o    <= pick;
                        rpt_cycle_o   <= snap_cycle[pick];
                        rpt_instret_o <= snap_instret[pick];
                        busy_o        <= 1'b1;
                        rem           <= '0;
                        quo           <= snap_instret[pick] * 64'd1000;
                        divisor       <= snap_cycle[pick];
                        if (snap_cycle[pick] == 64'd0) begin
                            rpt_mipc_o  <= '1;
                            rpt_valid_o <= 1'b1;
                            state       <= REPORT;
                        end else begin
                            cnt   <= 7'd64;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= fits ? diff : shifted[63:0];
                    quo <= quo_nxt;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        rpt_mipc_o  <= quo_nxt;
                        rpt_valid_o <= 1'b1;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (rpt_ready_i) begin
                        rpt_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ariane_host_finish_ctrl.sv
// Scoreboard bench for ariane_host_finish_ctrl: a model queues each expected report when an
// ECALL is accepted, and a negedge monitor pops and compares on every handshake.
module tb_ariane_host_finish_ctrl;

    localparam int NUM_HARTS = 2;
    localparam int HART_W    = 1;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic [NUM_HARTS-1:0]    ex_i = '0;
    logic [64*NUM_HARTS-1:0] cause_i = '0;
    logic [64*NUM_HARTS-1:0] cycle_i = '0;
    logic [64*NUM_HARTS-1:0] instret_i = '0;
    logic                    rpt_valid_o;
    logic                    rpt_ready_i = 1'b0;
    logic [HART_W-1:0]       rpt_hart_o;
    logic [63:0]             rpt_cycle_o;
    logic [63:0]             rpt_instret_o;
    logic [63:0]             rpt_mipc_o;
    logic                    busy_o;
    logic                    all_done_o;

    always #5 clk_i = ~clk_i;

    ariane_host_finish_ctrl #(.NUM_HARTS(NUM_HARTS), .HART_W(HART_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ex_i          (ex_i),
        .cause_i       (cause_i),
        .cycle_i       (cycle_i),
        .instret_i     (instret_i),
        .rpt_valid_o   (rpt_valid_o),
        .rpt_ready_i   (rpt_ready_i),
        .rpt_hart_o    (rpt_hart_o),
        .rpt_cycle_o   (rpt_cycle_o),
        .rpt_instret_o (rpt_instret_o),
        .rpt_mipc_o    (rpt_mipc_o),
        .busy_o        (busy_o),
        .all_done_o    (all_done_o)
    );

    typedef struct {
        logic [63:0] cycle;
        logic [63:0] instret;
        logic [63:0] mipc;
    } rpt_t;

    rpt_t exp_q [NUM_HARTS][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mipc(input logic [63:0] cyc, input logic [63:0] ins);
        logic [63:0] scaled;
        scaled = ins * 64'd1000;
        return (cyc == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : scaled / cyc;
    endfunction

    function automatic bit is_ecall(input logic [63:0] c);
        return (c == 64'h8) || (c == 64'h9) || (c == 64'hb);
    endfunction

    // Reference model: which harts are owed a report, and what that report must say.
    logic [NUM_HARTS-1:0] m_pend = '0;
    logic [NUM_HARTS-1:0] m_fin  = '0;
    logic                 hs_req = 1'b0;
    logic [HART_W-1:0]    hs_hart = '0;

    always @(posedge clk_i) begin
        rpt_t e;
        if (rst_i) begin
            m_pend <= '0;
            m_fin  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) exp_q[h].delete();
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (ex_i[h] && is_ecall(cause_i[64*h +: 64]) && !m_pend[h] && !m_fin[h]) begin
                    m_pend[h] <= 1'b1;
                    e.cycle   = cycle_i[64*h +: 64];
                    e.instret = instret_i[64*h +: 64];
                    e.mipc    = ref_mipc(e.cycle, e.instret);
                    exp_q[h].push_back(e);
                end
            end
            if (hs_req) begin
                m_pend[hs_hart] <= 1'b0;
                m_fin[hs_hart]  <= 1'b1;
            end
        end
    end

    // Monitor: compares on handshake, checks hold-while-stalled and all_done every cycle.
    logic              stall = 1'b0;
    logic [HART_W-1:0] s_hart;
    logic [63:0]       s_cycle, s_instret, s_mipc;

    always @(negedge clk_i) begin
        rpt_t e;
        if (!mon_en || rst_i) begin
            stall  <= 1'b0;
            hs_req <= 1'b0;
        end else begin
            check("all_done_track", all_done_o, &m_fin);
            if (stall) begin
                check("stall_valid_held", rpt_valid_o, 1);
                check("stall_hart_held", rpt_hart_o, s_hart);
                check("stall_cycle_held", rpt_cycle_o, s_cycle);
                check("stall_instret_held", rpt_instret_o, s_instret);
                check("stall_mipc_held", rpt_mipc_o, s_mipc);
            end
            if (rpt_valid_o && rpt_ready_i) begin
                check("report_was_due", exp_q[rpt_hart_o].size() != 0, 1);
                if (exp_q[rpt_hart_o].size() != 0) begin
                    e = exp_q[rpt_hart_o].pop_front();
                    check("rpt_cycle", rpt_cycle_o, e.cycle);
                    check("rpt_instret", rpt_instret_o, e.instret);
                    check("rpt_mipc", rpt_mipc_o, e.mipc);
                end
            end
            hs_req    <= rpt_valid_o && rpt_ready_i;
            hs_hart   <= rpt_hart_o;
            stall     <= rpt_valid_o && !rpt_ready_i;
            s_hart    <= rpt_hart_o;
            s_cycle   <= rpt_cycle_o;
            s_instret <= rpt_instret_o;
            s_mipc    <= rpt_mipc_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ex(input int h, input logic [63:0] cause, input logic [63:0] cyc,
                          input logic [63:0] ins);
        ex_i[h]              = 1'b1;
        cause_i[64*h +: 64]   = cause;
        cycle_i[64*h +: 64]   = cyc;
        instret_i[64*h +: 64] = ins;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, rpt_valid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_all_done"}, all_done_o, 0);
        check({tag, "_hart"}, rpt_hart_o, 0);
        check({tag, "_cycle"}, rpt_cycle_o, 0);
        check({tag, "_instret"}, rpt_instret_o, 0);
        check({tag, "_mipc"}, rpt_mipc_o, 0);
    endtask

    task automatic do_reset();
        ex_i  = '0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset");
        tick();
    endtask

    // Counts rising edges until rpt_valid_o is seen; ex_i is dropped after the first edge.
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(posedge clk_i);
            n++;
            if (n == 1) begin
                #1;
                ex_i = '0;
            end
            @(negedge clk_i);
            if (rpt_valid_o) break;
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (rpt_valid_o) cnt++;
        end
    endtask

    task automatic drain(input int max);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        ex_i = '0;
        rpt_ready_i = 1'b1;
        while (!done && n < max) begin
            @(negedge clk_i);
            done = !busy_o;
            for (int h = 0; h < NUM_HARTS; h++) if (exp_q[h].size() != 0) done = 1'b0;
            n++;
        end
        check("drain_complete", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic [63:0] c, ins;

        repeat (3) tick();
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);
        check_all_zero("init");
        tick();

        // Single ECALL on hart 0, then hart 1 completes the set.
        rpt_ready_i = 1'b1;
        set_ex(0, 64'hb, 64'd2000, 64'd1000);
        wait_valid(200, n);
        check("single_latency", n, 66);
        check("single_hart", rpt_hart_o, 0);
        check("single_mipc", rpt_mipc_o, 64'd500);
        tick();
        @(negedge clk_i);
        check("single_valid_drop", rpt_valid_o, 0);
        check("single_busy_drop", busy_o, 0);
        check("single_not_all_done", all_done_o, 0);
        tick();
        set_ex(1, 64'h9, 64'd10, 64'd7);
        wait_valid(200, n);
        check("second_latency", n, 66);
        check("second_mipc", rpt_mipc_o, 64'd700);
        tick();
        @(negedge clk_i);
        check("single_all_done", all_done_o, 1);
        tick();

        // Non-ECALL causes are filtered.
        do_reset();
        set_ex(0, 64'h2, 64'd4, 64'd9);
        tick();
        set_ex(0, 64'ha, 64'd4, 64'd9);
        set_ex(1, 64'h3, 64'd4, 64'd9);
        tick();
        ex_i = '0;
        cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (busy_o) cnt++;
        end
        check("filter_busy_cycles", cnt, 0);
        tick();
        set_ex(0, 64'h8, 64'd4, 64'd9);
        wait_valid(200, n);
        check("filter_then_ecall_latency", n, 66);
        check("filter_then_ecall_mipc", rpt_mipc_o, 64'd2250);
        tick();

        // Simultaneous ECALLs, consumer stalls the first report.
        do_reset();
        rpt_ready_i = 1'b0;
        set_ex(0, 64'h8, 64'd1000, 64'd3000);
        set_ex(1, 64'hb, 64'd3, 64'd1);
        wait_valid(200, n);
        check("simul_latency", n, 66);
        repeat (10) tick();
        @(negedge clk_i);
        check("simul_first_valid", rpt_valid_o, 1);
        check("simul_first_hart", rpt_hart_o, 0);
        check("simul_first_mipc", rpt_mipc_o, 64'd3000);
        tick();
        rpt_ready_i = 1'b1;
        wait_valid(200, n);
        check("simul_second_latency", n, 66);
        check("simul_second_hart", rpt_hart_o, 1);
        check("simul_second_mipc", rpt_mipc_o, 64'd333);
        tick();
        @(negedge clk_i);
        check("simul_all_done", all_done_o, 1);
        tick();

        // Zero cycle count bypasses the divider.
        do_reset();
        set_ex(0, 64'hb, 64'd0, 64'd5);
        wait_valid(200, n);
        check("zero_latency", n, 2);
        check("zero_mipc", rpt_mipc_o, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // A second ECALL while pending leaves the snapshot alone.
        do_reset();
        set_ex(0, 64'hb, 64'd100, 64'd50);
        tick();
        ex_i = '0;
        repeat (10) tick();
        set_ex(0, 64'hb, 64'd999, 64'd77);
        wait_valid(200, n);
        check("retrig_latency", n, 55);
        check("retrig_cycle", rpt_cycle_o, 64'd100);
        check("retrig_instret", rpt_instret_o, 64'd50);
        tick();
        set_ex(0, 64'h8, 64'd999, 64'd77);
        tick();
        ex_i = '0;
        count_valid(100, cnt);
        check("retrig_no_second_report", cnt, 0);
        tick();

        // Reset in the middle of a divide.
        do_reset();
        set_ex(0, 64'hb, 64'd40, 64'd80);
        tick();
        ex_i = '0;
        repeat (29) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("middiv_reset");
        count_valid(100, cnt);
        check("middiv_no_report", cnt, 0);
        check("middiv_busy", busy_o, 0);
        tick();
        set_ex(1, 64'h9, 64'd8, 64'd4);
        wait_valid(200, n);
        check("after_reset_latency", n, 66);
        check("after_reset_mipc", rpt_mipc_o, 64'd500);
        tick();
        set_ex(0, 64'h8, 64'd7, 64'd7);
        wait_valid(200, n);
        check("after_reset_hart0_latency", n, 66);
        check("after_reset_hart0_mipc", rpt_mipc_o, 64'd1000);
        tick();
        @(negedge clk_i);
        check("after_reset_all_done", all_done_o, 1);
        tick();

        // Randomized episodes checked by the scoreboard.
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 200; cyc++) begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    ex_i[h] = ($urandom_range(0, 7) == 0);
                    case ($urandom_range(0, 5))
                        0:       cause_i[64*h +: 64] = 64'h8;
                        1:       cause_i[64*h +: 64] = 64'h9;
                        2:       cause_i[64*h +: 64] = 64'hb;
                        3:       cause_i[64*h +: 64] = 64'h2;
                        4:       cause_i[64*h +: 64] = 64'ha;
                        default: cause_i[64*h +: 64] = {$urandom, $urandom};
                    endcase
                    case ($urandom_range(0, 9))
                        0:                c = 64'd0;
                        1, 2, 3, 4, 5:    c = 64'($urandom_range(1, 5000));
                        default:          c = {$urandom, $urandom};
                    endcase
                    ins = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 100000))
                                                      : {$urandom, $urandom};
                    cycle_i[64*h +: 64]   = c;
                    instret_i[64*h +: 64] = ins;
                end
                rpt_ready_i = ($urandom_range(0, 2) != 0);
                tick();
            end
            drain(400);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
